// File: rtl/vending_pkg.sv
// Shared coin-path definitions for coin_acceptor and vending_Controller.
// Pure declarations, no timing and no flow control.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_ACCEPT,
    ST_REJECT,
    ST_HOLDOFF
  } coin_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin mechanism / controller side-band bundle for coin_acceptor.
// Wires only; no timing and no backpressure (strobes are fire-and-forget).
interface coin_acceptor_if;

  logic [1:0] raw_coin;
  logic       raw_strobe;
  logic       raw_return;
  logic       enable;
  logic [1:0] coin;
  logic       coin_insert;
  logic       coin_return;
  logic       reject_gate;
  logic       busy;

  modport master (
    output raw_coin, raw_strobe, raw_return, enable,
    input  coin, coin_insert, coin_return, reject_gate, busy
  );

  modport slave (
    input  raw_coin, raw_strobe, raw_return, enable,
    output coin, coin_insert, coin_return, reject_gate, busy
  );

endinterface

// File: rtl/coin_acceptor_debounce_sync.sv
// 2-flop sync + symmetric debounce of a bouncy line; one-cycle pulse on each debounced rise.
// Pulse appears CYCLES+2 edges after the raw rise; no backpressure.
module debounce_sync #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic rise
);

  localparam int            CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw_in;
      sync_q  <= meta_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter tracks consecutive samples disagreeing with the stable level.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync_q;
        rise_d  = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: sync/debounce strobe, validate code, emit insert/return strobes or drive reject flap.
// Decision DEBOUNCE_CYCLES+3 edges after strobe rise; no backpressure, outputs are fire-and-forget.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REJECT_CYCLES   = 8,
  parameter int HOLDOFF_CYCLES  = 4,
  parameter int RETURN_DEBOUNCE = 4
) (
  input logic            clk,
  input logic            reset,
  coin_acceptor_if.slave bus
);

  localparam int            CW        = $clog2(max3(DEBOUNCE_CYCLES, REJECT_CYCLES, HOLDOFF_CYCLES)) + 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] REJ_LAST  = CW'(REJECT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);

  logic [1:0]    coin_meta_q, coin_sync_q;
  logic          strobe_meta_q, strobe_sync_q;
  coin_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    coin_q, coin_d;
  logic          return_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coin_meta_q   <= COIN_NONE;
      coin_sync_q   <= COIN_NONE;
      strobe_meta_q <= 1'b0;
      strobe_sync_q <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      coin_q        <= COIN_NONE;
    end else begin
      coin_meta_q   <= bus.raw_coin;
      coin_sync_q   <= coin_meta_q;
      strobe_meta_q <= bus.raw_strobe;
      strobe_sync_q <= strobe_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      coin_q        <= coin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coin_d  = coin_q;
    case (state_q)
      ST_IDLE: begin
        if (strobe_sync_q) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!strobe_sync_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          // enable is only looked at on this edge; earlier toggles are irrelevant
          cnt_d = '0;
          if (bus.enable && (coin_sync_q != COIN_NONE)) begin
            state_d = ST_ACCEPT;
            coin_d  = coin_sync_q;
          end else begin
            state_d = ST_REJECT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACCEPT: begin
        state_d = ST_HOLDOFF;
        cnt_d   = '0;
      end
      ST_REJECT: begin
        if (cnt_q == REJ_LAST) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        // any high sample restarts the quiet period, so a held strobe never re-arms
        if (strobe_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  debounce_sync #(
    .CYCLES (RETURN_DEBOUNCE)
  ) u_return_db (
    .clk    (clk),
    .reset  (reset),
    .raw_in (bus.raw_return),
    .rise   (return_pulse)
  );

  assign bus.coin        = coin_q;
  assign bus.coin_insert = (state_q == ST_ACCEPT);
  assign bus.reject_gate = (state_q == ST_REJECT);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.coin_return = return_pulse;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: table-driven coin cases, hand-written corner sequences,
// and a randomized run compared against a pulse-level reference model.
module tb_coin_acceptor;

  localparam int DC = 4;
  localparam int RC = 8;
  localparam int HC = 4;
  localparam int RD = 4;
  localparam int NR = 1500;

  logic clk = 1'b0;
  logic reset;

  coin_acceptor_if bus();

  coin_acceptor #(
    .DEBOUNCE_CYCLES (DC),
    .REJECT_CYCLES   (RC),
    .HOLDOFF_CYCLES  (HC),
    .RETURN_DEBOUNCE (RD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  int c_ins, c_rej, c_ret, c_both, f_evt, f_ret, rel;

  typedef struct {
    int         len;
    logic [1:0] code;
    logic       en;
    int         n_ins;
    int         n_rej;
    int         first;
    logic [1:0] coin;
  } vec_t;

  vec_t vecs[7];

  bit         s_strobe[NR];
  bit         s_ret[NR];
  bit         s_en[NR];
  logic [1:0] s_code[NR];
  bit         e_ins[NR+1];
  bit         e_rej[NR+1];
  bit         e_ret[NR+1];
  bit         acc_mark[NR+1];
  logic [1:0] acc_code[NR+1];
  logic [1:0] e_coin[NR+1];

  int         pos, len, dec;
  logic [1:0] cur;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    c_ins = 0; c_rej = 0; c_ret = 0; c_both = 0; f_evt = 0; f_ret = 0; rel = 0;
  endtask

  task automatic drive(input bit strobe, input bit ret, input int n);
    for (int k = 0; k < n; k++) begin
      bus.raw_strobe = strobe;
      bus.raw_return = ret;
      step();
      rel++;
      if (bus.coin_insert) c_ins++;
      if (bus.reject_gate) c_rej++;
      if (bus.coin_return) c_ret++;
      if (bus.coin_insert && bus.coin_return) c_both++;
      if ((bus.coin_insert || bus.reject_gate) && f_evt == 0) f_evt = rel;
      if (bus.coin_return && f_ret == 0) f_ret = rel;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.raw_strobe = 1'b0;
    bus.raw_return = 1'b0;
    bus.raw_coin   = 2'b00;
    bus.enable     = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    //          len code   en    ins rej first coin
    vecs[0] = '{10, 2'b11, 1'b1, 1, 0,  7, 2'b11};
    vecs[1] = '{ 2, 2'b10, 1'b1, 0, 0,  0, 2'b11};
    vecs[2] = '{10, 2'b00, 1'b1, 0, RC, 7, 2'b11};
    vecs[3] = '{10, 2'b10, 1'b0, 0, RC, 7, 2'b11};
    vecs[4] = '{ 5, 2'b01, 1'b1, 1, 0,  7, 2'b01};
    vecs[5] = '{ 4, 2'b10, 1'b1, 0, 0,  0, 2'b01};
    vecs[6] = '{60, 2'b10, 1'b1, 1, 0,  7, 2'b10};

    do_reset();
    check("reset coin", bus.coin, 0);
    check("reset coin_insert", bus.coin_insert, 0);
    check("reset coin_return", bus.coin_return, 0);
    check("reset reject_gate", bus.reject_gate, 0);
    check("reset busy", bus.busy, 0);

    for (int v = 0; v < 7; v++) begin
      clear_counts();
      bus.raw_coin = vecs[v].code;
      bus.enable   = vecs[v].en;
      drive(1'b1, 1'b0, vecs[v].len);
      drive(1'b0, 1'b0, 30);
      check($sformatf("vec%0d inserts", v), c_ins, vecs[v].n_ins);
      check($sformatf("vec%0d reject cycles", v), c_rej, vecs[v].n_rej);
      check($sformatf("vec%0d first event edge", v), f_evt, vecs[v].first);
      check($sformatf("vec%0d coin", v), bus.coin, vecs[v].coin);
      check($sformatf("vec%0d busy idle", v), bus.busy, 0);
    end

    // Bounce during holdoff: a 3-cycle low gap must not re-arm, a 4-cycle one must.
    clear_counts();
    bus.enable   = 1'b1;
    bus.raw_coin = 2'b11;
    drive(1'b1, 1'b0, 8);
    check("holdoff first coin", bus.coin, 3);
    drive(1'b0, 1'b0, 3);
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 4);
    bus.raw_coin = 2'b01;
    drive(1'b1, 1'b0, 8);
    drive(1'b0, 1'b0, 30);
    check("holdoff insert count", c_ins, 2);
    check("holdoff final coin", bus.coin, 1);

    // Return button: bounce then hold, release and press again.
    clear_counts();
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 2);
    drive(1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 2);
    drive(1'b0, 1'b1, 12);
    check("return first pulse count", c_ret, 1);
    check("return first pulse edge", f_ret, 8 + RD + 2);
    drive(1'b0, 1'b0, 12);
    drive(1'b0, 1'b1, 12);
    drive(1'b0, 1'b0, 12);
    check("return second press count", c_ret, 2);

    // Return press lined up so its pulse lands on the accept cycle.
    clear_counts();
    bus.raw_coin = 2'b10;
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 9);
    drive(1'b0, 1'b0, 30);
    check("coincide both", c_both, 1);
    check("coincide inserts", c_ins, 1);
    check("coincide returns", c_ret, 1);

    // Reset while debouncing.
    clear_counts();
    bus.raw_coin = 2'b01;
    drive(1'b1, 1'b0, 4);
    check("debounce busy", bus.busy, 1);
    reset          = 1'b1;
    bus.raw_strobe = 1'b0;
    #1;
    check("mid reset coin", bus.coin, 0);
    check("mid reset coin_insert", bus.coin_insert, 0);
    check("mid reset reject_gate", bus.reject_gate, 0);
    check("mid reset busy", bus.busy, 0);
    repeat (2) step();
    reset = 1'b0;
    clear_counts();
    drive(1'b0, 1'b0, 20);
    check("post reset no insert", c_ins, 0);
    check("post reset busy", bus.busy, 0);
    clear_counts();
    drive(1'b1, 1'b0, 8);
    drive(1'b0, 1'b0, 20);
    check("fresh coin inserts", c_ins, 1);
    check("fresh coin edge", f_evt, 7);
    check("fresh coin code", bus.coin, 1);

    // Randomized run: independent strobe pulses and button presses, expected outputs
    // derived per pulse from the edge-numbering rules.
    for (int i = 0; i < NR; i++) begin
      s_strobe[i] = 1'b0;
      s_ret[i]    = 1'b0;
      s_code[i]   = 2'($urandom_range(0, 3));
      s_en[i]     = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i <= NR; i++) begin
      e_ins[i] = 1'b0; e_rej[i] = 1'b0; e_ret[i] = 1'b0;
      acc_mark[i] = 1'b0; acc_code[i] = 2'b00;
    end
    pos = 2;
    while (pos < NR - 60) begin
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) s_strobe[pos + i] = 1'b1;
      if (len >= DC + 1) begin
        dec = pos + DC + 3;
        if (s_en[dec - 1] && s_code[dec - 3] != 2'b00) begin
          e_ins[dec]    = 1'b1;
          acc_mark[dec] = 1'b1;
          acc_code[dec] = s_code[dec - 3];
        end else begin
          for (int i = 0; i < RC; i++) e_rej[dec + i] = 1'b1;
        end
      end
      pos += len + $urandom_range(22, 35);
    end
    pos = 5;
    while (pos < NR - 40) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) s_ret[pos + i] = 1'b1;
      if (len >= RD) e_ret[pos + RD + 2] = 1'b1;
      pos += len + $urandom_range(6, 20);
    end
    cur = 2'b00;
    for (int e = 0; e <= NR; e++) begin
      if (acc_mark[e]) cur = acc_code[e];
      e_coin[e] = cur;
    end

    do_reset();
    for (int n = 0; n < NR; n++) begin
      bus.raw_strobe = s_strobe[n];
      bus.raw_return = s_ret[n];
      bus.raw_coin   = s_code[n];
      bus.enable     = s_en[n];
      step();
      check($sformatf("rnd coin_insert @%0d", n + 1), bus.coin_insert, e_ins[n + 1]);
      check($sformatf("rnd reject_gate @%0d", n + 1), bus.reject_gate, e_rej[n + 1]);
      check($sformatf("rnd coin_return @%0d", n + 1), bus.coin_return, e_ret[n + 1]);
      check($sformatf("rnd coin @%0d", n + 1), bus.coin, e_coin[n + 1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
